// File: rtl/fwft_pkt_reader_if.sv
// Bundles the FWFT FIFO read side and the outgoing stream of fwft_pkt_reader.
// master = the reader (pops the FIFO, drives the stream); slave = FIFO + sink.
interface fwft_pkt_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 11
);
  logic [DATA_WIDTH-1:0] fifo_dout_i;
  logic                  fifo_empty_i;
  logic [CNT_WIDTH-1:0]  fifo_num_i;
  logic                  fifo_rd_en_o;
  logic [DATA_WIDTH-1:0] m_tdata_o;
  logic                  m_tvalid_o;
  logic                  m_tready_i;
  logic                  m_tlast_o;
  logic                  m_tuser_o;

  modport master (
    input  fifo_dout_i, fifo_empty_i, fifo_num_i, m_tready_i,
    output fifo_rd_en_o, m_tdata_o, m_tvalid_o, m_tlast_o, m_tuser_o
  );

  modport slave (
    output fifo_dout_i, fifo_empty_i, fifo_num_i, m_tready_i,
    input  fifo_rd_en_o, m_tdata_o, m_tvalid_o, m_tlast_o, m_tuser_o
  );
endinterface

// File: rtl/fwft_pkt_reader.sv
// Waits for a full packet in an FWFT FIFO, emits a tagged header word, then
// streams PKT_LEN payload words straight from the FIFO head.
module fwft_pkt_reader #(
  parameter int          DATA_WIDTH = 32,
  parameter int          PKT_LEN    = 256,
  parameter int          CNT_WIDTH  = 11,
  parameter logic [15:0] HEAD_TAG   = 16'h5AA5
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  fwft_pkt_reader_if.master       bus,
  output logic                    busy_o,
  output logic                    err_underrun_o
);

  typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD} state_t;

  localparam logic [31:0] PKT_LEN_U = 32'(PKT_LEN);
  localparam logic [15:0] LAST_IDX  = 16'(PKT_LEN - 1);
  localparam int          HDR_BITS  = (DATA_WIDTH < 32) ? DATA_WIDTH : 32;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] seq_q, seq_d;
  logic        err_q, err_d;

  logic        pkt_ready;
  logic        pay_valid;
  logic        pay_last;
  logic        pop;

  // Header is {tag, seq}, zero-extended or truncated to the stream width.
  function automatic logic [DATA_WIDTH-1:0] header_word(input logic [15:0] seq);
    logic [31:0]           raw;
    logic [DATA_WIDTH-1:0] w;
    raw = {HEAD_TAG, seq};
    w   = '0;
    w[HDR_BITS-1:0] = raw[HDR_BITS-1:0];
    return w;
  endfunction

  assign pkt_ready = (32'(bus.fifo_num_i) >= PKT_LEN_U) && !bus.fifo_empty_i;
  assign pay_valid = (state_q == PAYLOAD) && !bus.fifo_empty_i;
  assign pay_last  = pay_valid && (cnt_q == LAST_IDX);
  assign pop       = pay_valid && bus.m_tready_i;

  always_comb begin
    bus.m_tvalid_o   = 1'b0;
    bus.m_tuser_o    = 1'b0;
    bus.m_tlast_o    = 1'b0;
    bus.m_tdata_o    = '0;
    bus.fifo_rd_en_o = 1'b0;
    case (state_q)
      HEAD: begin
        bus.m_tvalid_o = 1'b1;
        bus.m_tuser_o  = 1'b1;
        bus.m_tdata_o  = header_word(seq_q);
      end
      PAYLOAD: begin
        bus.m_tvalid_o   = pay_valid;
        bus.m_tlast_o    = pay_last;
        bus.m_tdata_o    = bus.fifo_dout_i;
        bus.fifo_rd_en_o = pop;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (pkt_ready) state_d = HEAD;
      end
      HEAD: begin
        if (bus.m_tready_i) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
        end
      end
      PAYLOAD: begin
        if (bus.fifo_empty_i) err_d = 1'b1;
        if (pop) begin
          cnt_d = cnt_q + 16'd1;
          if (pay_last) begin
            seq_d   = seq_q + 16'd1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seq_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign err_underrun_o = err_q;

endmodule

// File: tb/tb_fwft_pkt_reader.sv
// Scoreboard bench for fwft_pkt_reader with PKT_LEN=4 and a queue-based FWFT FIFO model.
module tb_fwft_pkt_reader;
  localparam int DW = 32;
  localparam int CW = 11;
  localparam int PL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err;

  always #5 clk = ~clk;

  fwft_pkt_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fwft_pkt_reader #(
    .DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(CW), .HEAD_TAG(16'h5AA5)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus.master),
    .busy_o(busy), .err_underrun_o(err)
  );

  // FWFT FIFO model: pops on rd_en at the rising edge, head visible after it.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] pend[$];
  logic [DW-1:0] dout_r  = '0;
  logic          empty_r = 1'b1;
  logic [CW-1:0] num_r   = '0;
  logic          force_empty = 1'b0;

  always @(posedge clk) begin
    if (bus.fifo_rd_en_o && fq.size() > 0) fq.delete(0);
    while (pend.size() > 0) fq.push_back(pend.pop_front());
    dout_r  <= (fq.size() > 0) ? fq[0] : '0;
    empty_r <= (fq.size() == 0);
    num_r   <= CW'(fq.size());
  end

  assign bus.fifo_dout_i  = dout_r;
  assign bus.fifo_empty_i = empty_r | force_empty;
  assign bus.fifo_num_i   = num_r;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  beat_t expq[$];
  int    exp_seq = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    hs_cnt = 0;
  int    pop_cnt = 0;
  int    last_cyc = -1;
  bit    gap_en = 1'b0;
  bit    prev_last = 1'b0;
  bit    prev_hdr_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  beat_t e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    pend.push_back(w);
  endtask

  task automatic exp_hdr();
    expq.push_back('{d: {16'h5AA5, 16'(exp_seq)}, u: 1'b1, l: 1'b0});
  endtask

  task automatic exp_frame(input logic [DW-1:0] w0);
    exp_hdr();
    for (int i = 0; i < PL; i++)
      expq.push_back('{d: w0 + DW'(i), u: 1'b0, l: (i == PL - 1)});
    exp_seq = (exp_seq + 1) & 16'hFFFF;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((expq.size() != 0 || busy) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) chk("done_timeout", 1, 0);
  endtask

  task automatic wait_hs(input int target);
    int t = 0;
    while (hs_cnt < target && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("hs_timeout", 1, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, bus.m_tvalid_o, 0);
    chk({tag, "_last"},  bus.m_tlast_o, 0);
    chk({tag, "_user"},  bus.m_tuser_o, 0);
    chk({tag, "_rd_en"}, bus.fifo_rd_en_o, 0);
    chk({tag, "_data"},  bus.m_tdata_o, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_err"},   err, 0);
  endtask

  // Monitor: scoreboard on every handshake plus per-cycle protocol checks.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.fifo_rd_en_o) begin
        pop_cnt++;
        chk("rd_when_empty", bus.fifo_empty_i, 0);
      end
      chk("rd_en", bus.fifo_rd_en_o,
          bus.m_tvalid_o & bus.m_tready_i & ~bus.m_tuser_o);
      if (!bus.m_tvalid_o) chk("flags_no_valid", {bus.m_tuser_o, bus.m_tlast_o}, 0);
      if (force_empty) chk("underrun_valid", bus.m_tvalid_o, 0);
      if (prev_last) chk("busy_after_last", busy, 0);
      if (prev_hdr_stall)
        chk("hdr_hold", {bus.m_tvalid_o, bus.m_tuser_o, bus.m_tdata_o}, {2'b11, prev_data});
      if (bus.m_tvalid_o && bus.m_tready_i) begin
        hs_cnt++;
        if (expq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("data", bus.m_tdata_o, e.d);
          chk("tuser", bus.m_tuser_o, e.u);
          chk("tlast", bus.m_tlast_o, e.l);
        end
        if (bus.m_tuser_o && gap_en && last_cyc >= 0) chk("idle_gap", cyc - last_cyc, 2);
        if (bus.m_tlast_o) last_cyc = cyc;
      end
      prev_last      = bus.m_tvalid_o & bus.m_tready_i & bus.m_tlast_o;
      prev_hdr_stall = bus.m_tvalid_o & bus.m_tuser_o & ~bus.m_tready_i;
      prev_data      = bus.m_tdata_o;
    end else begin
      prev_last      = 1'b0;
      prev_hdr_stall = 1'b0;
    end
  end

  initial begin
    int base;
    bus.m_tready_i = 1'b1;
    rst_n = 1'b0;

    // Single frame from a preloaded FIFO
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    exp_frame(32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_done();
    chk("pops_frame1", pop_cnt, 4);

    // Back-to-back frames, seq 1 then 2, one idle cycle apart
    gap_en = 1'b1;
    last_cyc = -1;
    for (int i = 11; i <= 18; i++) push_word(DW'(i));
    exp_frame(32'd11);
    exp_frame(32'd15);
    wait_done();
    gap_en = 1'b0;

    // Below threshold: no start until the count reaches PKT_LEN
    base = pop_cnt;
    for (int i = 21; i <= 23; i++) push_word(DW'(i));
    repeat (6) @(posedge clk);
    #1;
    chk("short_busy", busy, 0);
    chk("short_num", bus.fifo_num_i, 3);
    chk("short_pops", pop_cnt, base);
    exp_frame(32'd21);
    push_word(32'd24);
    @(posedge clk); #1;
    chk("num_reached", bus.fifo_num_i, 4);
    chk("still_idle", busy, 0);
    @(posedge clk); #1;
    chk("hdr_next_cycle", {bus.m_tvalid_o, bus.m_tuser_o}, 2'b11);
    wait_done();

    // Ready toggling throughout a frame
    bus.m_tready_i = 1'b0;
    for (int i = 31; i <= 34; i++) push_word(DW'(i));
    exp_frame(32'd31);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      bus.m_tready_i = ~bus.m_tready_i;
      if (expq.size() == 0 && !busy) break;
    end
    bus.m_tready_i = 1'b1;
    wait_done();

    // Underrun for three cycles mid-payload
    for (int i = 41; i <= 44; i++) push_word(DW'(i));
    exp_frame(32'd41);
    base = hs_cnt;
    wait_hs(base + 2);
    force_empty = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    force_empty = 1'b0;
    chk("err_set", err, 1);
    wait_done();
    chk("err_sticky", err, 1);

    // Reset after the second payload word
    for (int i = 51; i <= 54; i++) push_word(DW'(i));
    exp_hdr();
    expq.push_back('{d: 32'd51, u: 1'b0, l: 1'b0});
    expq.push_back('{d: 32'd52, u: 1'b0, l: 1'b0});
    base = hs_cnt;
    wait_hs(base + 3);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midpkt_reset");
    exp_seq = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("after_reset_idle", busy, 0);
    exp_hdr();
    for (int i = 53; i <= 56; i++)
      expq.push_back('{d: DW'(i), u: 1'b0, l: (i == 56)});
    push_word(32'd55);
    push_word(32'd56);
    wait_done();

    chk("sb_empty", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
